vga_frame_scheduler: RTL and testbench
======================================

VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

Interface
REQ-001 The block SHALL have parameter V_ACTIVE, default 480; first non-visible line.
REQ-002 The block SHALL have parameter V_MAX, default 525; last line index of a frame.
REQ-003 The block SHALL have parameter SPEED_DIV, default 4; frames per game tick, legal range 1..255.
REQ-004 The block SHALL have port VGA_clk  input  1  pixel clock; the only clock.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port xCount  input  10  horizontal pixel counter from the VGA timing generator.
REQ-007 The block SHALL have port yCount  input  10  vertical line counter from the VGA timing generator.
REQ-008 The block SHALL have port pause  input  1  suppresses gameTick while high.
REQ-009 The block SHALL have port req  input  2  update-access requests; bit0 snake logic, bit1 score logic.
REQ-010 The block SHALL have port done  input  2  per-requester completion strobe, one cycle.
REQ-011 The block SHALL have port grant  output  2  one-hot-or-zero access grant, registered.
REQ-012 The block SHALL have port inBlank  output  1  high while the scheduler is in the vertical-blank window.
REQ-013 The block SHALL have port gameTick  output  1  one-cycle game-step pulse.
REQ-014 The block SHALL have port overrun  output  1  one-cycle pulse when a grant is revoked by window close.
REQ-015 The block SHALL have port frameCount  output  8  completed-frame counter.

Function
REQ-016 The block SHALL implement FSM states ACTIVE, ARB, GRANT; all outputs registered.
REQ-017 ACTIVE SHALL move to ARB on the cycle where yCount==V_ACTIVE and xCount==0; inBlank rises the next cycle.
REQ-018 On that same ACTIVE->ARB cycle, frameCount SHALL increment by 1, wrapping 255->0.
REQ-019 A frame divider (0..SPEED_DIV-1) SHALL advance on each ACTIVE->ARB entry; when it wraps to 0 and pause is low, gameTick SHALL pulse high for exactly one cycle, coincident with inBlank rising.
REQ-020 When pause is high at divider wrap, the divider SHALL still wrap and gameTick SHALL stay low; no tick is deferred.
REQ-021 In ACTIVE, req SHALL be ignored and grant SHALL be 0.
REQ-022 In ARB with any req bit set, the block SHALL grant one requester, with grant visible the next cycle, and enter GRANT.
REQ-023 Arbitration SHALL be round-robin: the requester not granted last has priority; after reset, bit0 has priority.
REQ-024 In GRANT, grant SHALL hold stable until done of the granted bit is sampled high; done of the non-granted bit SHALL be ignored.
REQ-025 On a sampled granted done, grant SHALL clear the next cycle, last-granted SHALL update, and the FSM SHALL return to ARB; the earliest next grant is 2 cycles after done.
REQ-026 Window close SHALL occur when yCount==V_MAX and xCount==0; from ARB or GRANT the FSM SHALL go to ACTIVE and clear grant and inBlank the next cycle.
REQ-027 If window close occurs in GRANT without the granted done in that same cycle, overrun SHALL pulse for one cycle and last-granted SHALL update.
REQ-028 If granted done and window close occur in the same cycle, done SHALL win: no overrun, and the FSM SHALL go to ACTIVE.
REQ-029 If a granted req drops without done, grant SHALL persist; only done or window close releases it.

Reset
REQ-030 Asserting reset_n low SHALL immediately force state ACTIVE, grant=0, inBlank=0, gameTick=0, overrun=0, frameCount=0, divider=0, last-granted=bit1, including mid-grant.
REQ-031 After reset_n rises, the block SHALL wait for the next ACTIVE->ARB condition; a reset released inside blanking SHALL NOT grant until the following frame.

Verification
REQ-032 Bench SHALL cover: SPEED_DIV=4, 8 frames, pause=0 -> gameTick exactly on frames 4 and 8 at yCount=480,xCount=1; frameCount=8.
REQ-033 Bench SHALL cover: req=2'b11 held at blank entry, each done 3 cycles after grant -> grant sequence 01,00,10,00,01 with 1-cycle gaps.
REQ-034 Bench SHALL cover: grant=01, no done until yCount=525,xCount=0 -> grant=00 and overrun=1 for one cycle, inBlank=0; next blank grants 10 first.
REQ-035 Bench SHALL cover: done[0] coincident with window close -> overrun stays 0, grant=00.
REQ-036 Bench SHALL cover: pause=1 over divider wrap -> no gameTick; frameCount still increments.
REQ-037 Bench SHALL cover: reset_n low mid-GRANT -> grant=00 asynchronously; req during yCount<480 -> grant remains 00.

Source files
------------

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler
// Opens an update window during vertical blanking, arbitrates access to the
// game-state update logic between two requesters (snake, score) round-robin,
// and produces the frame counter and the divided game-step tick.
module vga_frame_scheduler #(
  parameter int V_ACTIVE  = 480,
  parameter int V_MAX     = 525,
  parameter int SPEED_DIV = 4
) (
  input  logic       VGA_clk,
  input  logic       reset_n,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic       pause,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] grant,
  output logic       inBlank,
  output logic       gameTick,
  output logic       overrun,
  output logic [7:0] frameCount
);

  localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);
  localparam logic [9:0] V_MAX_L    = 10'(V_MAX);
  localparam logic [7:0] DIV_LAST   = 8'(SPEED_DIV - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_ARB    = 2'd1,
    ST_GRANT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       in_blank_q, in_blank_d;
  logic       tick_q, tick_d;
  logic       overrun_q, overrun_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] div_q, div_d;
  // Index of the requester granted most recently (0 = snake, 1 = score).
  logic       last_q, last_d;

  logic       blank_open;
  logic       blank_close;
  logic       granted_done;
  logic [7:0] div_next;

  // Round-robin pick: with both requesting, the one not served last wins.
  // A single requester is granted directly; zero requests yield zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] r, input logic last);
    logic [1:0] pick;
    pick = r;
    if (r == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
    return pick;
  endfunction

  assign blank_open   = (yCount == V_ACTIVE_L) && (xCount == 10'd0);
  assign blank_close  = (yCount == V_MAX_L) && (xCount == 10'd0);
  // Only the done bit of the currently granted requester counts.
  assign granted_done = |(done & grant_q);
  assign div_next     = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;

  // Next-state and registered-output computation for the window FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    in_blank_d = in_blank_q;
    tick_d     = 1'b0;
    overrun_d  = 1'b0;
    frame_d    = frame_q;
    div_d      = div_q;
    last_d     = last_q;

    case (state_q)
      ST_ACTIVE: begin
        grant_d    = 2'b00;
        in_blank_d = 1'b0;
        if (blank_open) begin
          state_d    = ST_ARB;
          in_blank_d = 1'b1;
          frame_d    = frame_q + 8'd1;
          div_d      = div_next;
          // A paused wrap is simply lost; the tick is not held over.
          tick_d     = (div_next == 8'd0) && !pause;
        end
      end

      ST_ARB: begin
        if (blank_close) begin
          state_d    = ST_ACTIVE;
          grant_d    = 2'b00;
          in_blank_d = 1'b0;
        end else if (|req) begin
          state_d = ST_GRANT;
          grant_d = rr_pick(req, last_q);
        end
      end

      ST_GRANT: begin
        if (granted_done) begin
          // Completion beats a coincident window close: no overrun.
          grant_d = 2'b00;
          last_d  = grant_q[1];
          if (blank_close) begin
            state_d    = ST_ACTIVE;
            in_blank_d = 1'b0;
          end else begin
            state_d = ST_ARB;
          end
        end else if (blank_close) begin
          // Window ran out under an active grant: revoke and flag it.
          state_d    = ST_ACTIVE;
          grant_d    = 2'b00;
          in_blank_d = 1'b0;
          overrun_d  = 1'b1;
          last_d     = grant_q[1];
        end
      end

      default: begin
        state_d    = ST_ACTIVE;
        grant_d    = 2'b00;
        in_blank_d = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output, counter and arbitration-history registers.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q    <= 2'b00;
      in_blank_q <= 1'b0;
      tick_q     <= 1'b0;
      overrun_q  <= 1'b0;
      frame_q    <= 8'd0;
      div_q      <= 8'd0;
      last_q     <= 1'b1;
    end else begin
      grant_q    <= grant_d;
      in_blank_q <= in_blank_d;
      tick_q     <= tick_d;
      overrun_q  <= overrun_d;
      frame_q    <= frame_d;
      div_q      <= div_d;
      last_q     <= last_d;
    end
  end

  assign grant      = grant_q;
  assign inBlank    = in_blank_q;
  assign gameTick   = tick_q;
  assign overrun    = overrun_q;
  assign frameCount = frame_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed testbench for vga_frame_scheduler (default parameters).
module tb_vga_frame_scheduler;

  logic       VGA_clk = 1'b0;
  logic       reset_n;
  logic [9:0] xCount;
  logic [9:0] yCount;
  logic       pause;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] grant;
  logic       inBlank;
  logic       gameTick;
  logic       overrun;
  logic [7:0] frameCount;

  int vecs = 0;
  int errs = 0;

  vga_frame_scheduler #(.V_ACTIVE(480), .V_MAX(525), .SPEED_DIV(4)) dut (
    .VGA_clk   (VGA_clk),
    .reset_n   (reset_n),
    .xCount    (xCount),
    .yCount    (yCount),
    .pause     (pause),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .inBlank   (inBlank),
    .gameTick  (gameTick),
    .overrun   (overrun),
    .frameCount(frameCount)
  );

  always #5 VGA_clk = ~VGA_clk;

  // Advance n clock edges; leave time 1 unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge VGA_clk);
      #1;
    end
  endtask

  // Present the blank-entry position for one edge, then move on to x=1.
  task automatic enter_blank();
    yCount = 10'd480; xCount = 10'd0;
    tick(1);
    xCount = 10'd1;
  endtask

  // Present the window-close position for one edge, then move to the next frame.
  task automatic close_window();
    yCount = 10'd525; xCount = 10'd0;
    tick(1);
    yCount = 10'd0; xCount = 10'd1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pause = 1'b0; req = 2'b00; done = 2'b00;
    yCount = 10'd100; xCount = 10'd5;
    tick(2);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant got %b exp %b", grant, 2'b00); end
    vecs++; if (inBlank !== 1'b0) begin errs++; $display("FAIL reset_inBlank got %b exp %b", inBlank, 1'b0); end
    vecs++; if (gameTick !== 1'b0) begin errs++; $display("FAIL reset_gameTick got %b exp %b", gameTick, 1'b0); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b exp %b", overrun, 1'b0); end
    vecs++; if (frameCount !== 8'd0) begin errs++; $display("FAIL reset_frameCount got %0d exp %0d", frameCount, 0); end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_game_tick();
    logic exp_tick;
    for (int f = 1; f <= 8; f++) begin
      exp_tick = ((f % 4) == 0);
      enter_blank();
      vecs++; if (gameTick !== exp_tick) begin errs++; $display("FAIL tick_frame%0d got %b exp %b", f, gameTick, exp_tick); end
      vecs++; if (inBlank !== 1'b1) begin errs++; $display("FAIL tick_inBlank%0d got %b exp %b", f, inBlank, 1'b1); end
      vecs++; if (frameCount !== 8'(f)) begin errs++; $display("FAIL tick_frameCount%0d got %0d exp %0d", f, frameCount, f); end
      tick(1);
      vecs++; if (gameTick !== 1'b0) begin errs++; $display("FAIL tick_width%0d got %b exp %b", f, gameTick, 1'b0); end
      close_window();
      vecs++; if (inBlank !== 1'b0) begin errs++; $display("FAIL tick_close%0d got %b exp %b", f, inBlank, 1'b0); end
    end
    vecs++; if (frameCount !== 8'd8) begin errs++; $display("FAIL tick_total got %0d exp %0d", frameCount, 8); end
  endtask

  task automatic test_pause();
    pause = 1'b1;
    for (int f = 9; f <= 12; f++) begin
      enter_blank();
      vecs++; if (gameTick !== 1'b0) begin errs++; $display("FAIL pause_tick%0d got %b exp %b", f, gameTick, 1'b0); end
      vecs++; if (frameCount !== 8'(f)) begin errs++; $display("FAIL pause_frameCount%0d got %0d exp %0d", f, frameCount, f); end
      close_window();
    end
    pause = 1'b0;
    enter_blank();
    vecs++; if (gameTick !== 1'b0) begin errs++; $display("FAIL pause_no_defer got %b exp %b", gameTick, 1'b0); end
    vecs++; if (frameCount !== 8'd13) begin errs++; $display("FAIL pause_frame13 got %0d exp %0d", frameCount, 13); end
    close_window();
  endtask

  task automatic test_round_robin();
    req = 2'b11;
    enter_blank();
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL rr_entry got %b exp %b", grant, 2'b00); end
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rr_first got %b exp %b", grant, 2'b01); end
    done = 2'b10;
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rr_other_done got %b exp %b", grant, 2'b01); end
    done = 2'b00;
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rr_hold0 got %b exp %b", grant, 2'b01); end
    done = 2'b01;
    tick(1);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL rr_gap1 got %b exp %b", grant, 2'b00); end
    done = 2'b00;
    tick(1);
    vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL rr_second got %b exp %b", grant, 2'b10); end
    tick(2);
    vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL rr_hold1 got %b exp %b", grant, 2'b10); end
    done = 2'b10;
    tick(1);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL rr_gap2 got %b exp %b", grant, 2'b00); end
    done = 2'b00;
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rr_third got %b exp %b", grant, 2'b01); end
    req = 2'b00; done = 2'b01;
    tick(1);
    done = 2'b00;
    close_window();
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL rr_close_overrun got %b exp %b", overrun, 1'b0); end
    vecs++; if (inBlank !== 1'b0) begin errs++; $display("FAIL rr_close_inBlank got %b exp %b", inBlank, 1'b0); end
  endtask

  task automatic test_overrun();
    req = 2'b01;
    enter_blank();
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL ovr_grant got %b exp %b", grant, 2'b01); end
    req = 2'b00;
    tick(2);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL ovr_req_drop got %b exp %b", grant, 2'b01); end
    yCount = 10'd525; xCount = 10'd0;
    tick(1);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL ovr_revoke got %b exp %b", grant, 2'b00); end
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_pulse got %b exp %b", overrun, 1'b1); end
    vecs++; if (inBlank !== 1'b0) begin errs++; $display("FAIL ovr_inBlank got %b exp %b", inBlank, 1'b0); end
    yCount = 10'd0; xCount = 10'd1;
    tick(1);
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_width got %b exp %b", overrun, 1'b0); end
    req = 2'b11;
    enter_blank();
    tick(1);
    vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL ovr_next_first got %b exp %b", grant, 2'b10); end
    req = 2'b00; done = 2'b10;
    tick(1);
    done = 2'b00;
    close_window();
  endtask

  task automatic test_done_close();
    req = 2'b11;
    enter_blank();
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL dc_grant got %b exp %b", grant, 2'b01); end
    tick(1);
    yCount = 10'd525; xCount = 10'd0; done = 2'b01;
    tick(1);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL dc_grant_clear got %b exp %b", grant, 2'b00); end
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL dc_overrun got %b exp %b", overrun, 1'b0); end
    vecs++; if (inBlank !== 1'b0) begin errs++; $display("FAIL dc_inBlank got %b exp %b", inBlank, 1'b0); end
    yCount = 10'd0; xCount = 10'd1; done = 2'b00;
    tick(1);
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL dc_overrun_late got %b exp %b", overrun, 1'b0); end
    tick(2);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL dc_active_ignore got %b exp %b", grant, 2'b00); end
    req = 2'b00;
  endtask

  task automatic test_reset_midgrant();
    req = 2'b01;
    enter_blank();
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rst_pre_grant got %b exp %b", grant, 2'b01); end
    #2 reset_n = 1'b0;
    #1;
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL rst_async_grant got %b exp %b", grant, 2'b00); end
    vecs++; if (inBlank !== 1'b0) begin errs++; $display("FAIL rst_async_inBlank got %b exp %b", inBlank, 1'b0); end
    vecs++; if (frameCount !== 8'd0) begin errs++; $display("FAIL rst_async_frame got %0d exp %0d", frameCount, 0); end
    tick(1);
    yCount = 10'd490; xCount = 10'd3; req = 2'b11;
    reset_n = 1'b1;
    tick(3);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL rst_blank_release got %b exp %b", grant, 2'b00); end
    yCount = 10'd100;
    tick(2);
    vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL rst_active_req got %b exp %b", grant, 2'b00); end
    vecs++; if (inBlank !== 1'b0) begin errs++; $display("FAIL rst_active_inBlank got %b exp %b", inBlank, 1'b0); end
    enter_blank();
    vecs++; if (frameCount !== 8'd1) begin errs++; $display("FAIL rst_first_frame got %0d exp %0d", frameCount, 1); end
    tick(1);
    vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rst_bit0_priority got %b exp %b", grant, 2'b01); end
    req = 2'b00; done = 2'b01;
    tick(1);
    done = 2'b00;
    close_window();
  endtask

  task automatic test_frame_wrap();
    for (int i = 0; i < 254; i++) begin
      enter_blank();
      close_window();
    end
    vecs++; if (frameCount !== 8'd255) begin errs++; $display("FAIL wrap_255 got %0d exp %0d", frameCount, 255); end
    enter_blank();
    vecs++; if (frameCount !== 8'd0) begin errs++; $display("FAIL wrap_0 got %0d exp %0d", frameCount, 0); end
    close_window();
  endtask

  initial begin
    test_reset();
    test_game_tick();
    test_pause();
    test_round_robin();
    test_overrun();
    test_done_close();
    test_reset_midgrant();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
